cfg_loader: RTL and testbench
=============================

# cfg_loader

Bitstream loader that sequences the fabric's configuration scan chain. Accepts configuration words from a host-side valid/ready stream, serializes them MSB-first onto `cfg_head`, and gates `cfg_en` so exactly `CHAIN_LEN` bits are shifted into the chain. Sits between the configuration port and the `ConfigChain` instances, sharing their `cfg_clk`. Reports load progress and whether the loaded configuration is valid.

## Interface
- `CHAIN_LEN`, 16: total scan-chain length in bits, ≥1.
- `WORD_W`, 8: bitstream word width, ≥2.
- `NWORDS`, derived: ceil(CHAIN_LEN/WORD_W); not overridable.

- `cfg_clk` in 1: the single clock; the chain is clocked by the same net.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle load request; honoured only in IDLE.
- `abort` in 1: cancel the load in progress.
- `word_valid` in 1: host word available.
- `word_data` in WORD_W: host word; bit WORD_W-1 is shifted first.
- `word_ready` out 1: the loader accepts `word_data` this cycle.
- `cfg_en` out 1: chain shift enable.
- `cfg_head` out 1: serial data into the chain.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `cfg_valid` out 1: the chain holds a complete, unaborted configuration.

## Operation
- States (enum): IDLE, LOAD (waiting for a word), SHIFT, DONE.
- Reset: state=IDLE; shift register, bit and word counters = 0.
  - Reset outputs: `cfg_en`=0, `cfg_head`=0, `word_ready`=0, `busy`=0, `done`=0, `cfg_valid`=0.
- IDLE: when `start`=1, go to LOAD and clear `cfg_valid` at the same edge. `start` in any other state is ignored.
- LOAD: `word_ready`=1, `cfg_en`=0, so the chain holds.
  - On `word_valid`&&`word_ready`, load the shift register and go to SHIFT.
  - Bits in the word = min(WORD_W, remaining).
- SHIFT:
  - `cfg_en`=1 and `cfg_head`=shift register MSB; shift left by 1 per cycle.
  - Remaining-bit counter decrements by 1 per cycle.
  - Last bit of a word with more bits outstanding: `word_ready`=1.
    - If a word is accepted, the next cycle is SHIFT of the new word (zero-bubble).
    - Otherwise go to LOAD.
  - Last bit of the whole chain: go to DONE; `word_ready`=0.
- DONE: `done`=1 for one cycle, `cfg_valid` set to 1, then go to IDLE.
- Partial final word: when CHAIN_LEN mod WORD_W = r ≠ 0, only bits [WORD_W-1 : WORD_W-r] of the last word are shifted. The low bits are discarded.
- Chain mapping: the first bit shifted ends at chain position CHAIN_LEN-1; the last bit shifted ends at position 0.
- `abort`:
  - Highest priority. Sampled at the edge; the next state is IDLE.
  - `cfg_valid` stays 0, `done` does not pulse, counters clear.
  - A bit presented during the abort cycle in SHIFT is still shifted.
  - `abort` in IDLE has no effect.
- Simultaneous `start`+`abort` in IDLE: `abort` wins and the state stays IDLE, but `cfg_valid` is still cleared.
- Counters: the bit counter is $clog2(CHAIN_LEN+1) wide, so no wrap-around.

## Timing
- `cfg_en`, `cfg_head`, `word_ready`, `busy` and `done` are decoded from registered state only, with no combinational path from inputs.
  - Exception: `word_ready` in the last SHIFT cycle depends only on registered counters.
- Latency with `word_valid` held high: `start` sampled at edge 0.
  - LOAD in cycle 1, word accepted at edge 1.
  - SHIFT in cycles 2 … CHAIN_LEN+1.
  - DONE in cycle CHAIN_LEN+2; `cfg_valid`=1 from cycle CHAIN_LEN+3.
- Each LOAD cycle spent stalling adds exactly one cycle; chain contents are unchanged during the stall.
- `rst_n` low mid-load: immediate IDLE. Chain contents are undefined, and `cfg_valid`=0.

## Structure
- Package `cfg_pkg`: state enum `cfg_state_e`, plus a `cfg_nwords` helper function for ceil division.
- Sub-module `cfg_serializer`: WORD_W-bit load/shift register with MSB output. The FSM and counters stay in `cfg_loader`.

## Test plan
- CHAIN_LEN=16, WORD_W=8; words 0xA5, 0x3C with `word_valid` held high.
  - Expect 16 contiguous `cfg_en` cycles.
  - Chain `out`=0xA53C.
  - `done` in cycle 18; `cfg_valid`=1 in cycle 19.
- Same load, with `word_valid` of the second word withheld 3 cycles → 3 LOAD stall cycles with `cfg_en`=0, final `out`=0xA53C, `done` 3 cycles later.
- CHAIN_LEN=20, WORD_W=8; words 0xFF, 0x00, 0x9F → exactly 20 shifts, `out`=0xFF009 (low nibble 0xF discarded).
- `abort` during the 5th SHIFT cycle → IDLE next cycle, 5 shifts total, no `done`, `cfg_valid`=0; a subsequent full load succeeds.
- `start` pulsed while `busy` → ignored, with no extra shifts; `start`+`abort` together in IDLE → remain IDLE with `cfg_valid`=0.
- `rst_n` asserted asynchronously mid-SHIFT → all outputs 0 immediately; a fresh `start` reloads correctly.

Source files
------------

// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================
// cfg_pkg : shared state encoding and sizing helper for cfg_loader
// Rev 1.0
// ============================================================
package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } cfg_state_e;

    function automatic int cfg_nwords(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_loader_if.sv
`default_nettype none
// ============================================================
// cfg_loader_if : host word stream, control and chain-side outputs
// Rev 1.0
// ============================================================
interface cfg_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic              abort;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              cfg_en;
    logic              cfg_head;
    logic              busy;
    logic              done;
    logic              cfg_valid;

    modport master (
        output start, abort, word_valid, word_data,
        input  word_ready, cfg_en, cfg_head, busy, done, cfg_valid
    );

    modport slave (
        input  start, abort, word_valid, word_data,
        output word_ready, cfg_en, cfg_head, busy, done, cfg_valid
    );
endinterface
`default_nettype wire

// File: rtl/cfg_serializer.sv
`default_nettype none
// ============================================================
// cfg_serializer : load/shift-left register presenting its MSB
// Rev 1.0
// ============================================================
module cfg_serializer #(
    parameter int WORD_W = 8
) (
    input  wire logic              cfg_clk,
    input  wire logic              rst_n,
    input  wire logic              clear_i,
    input  wire logic              load_i,
    input  wire logic              shift_i,
    input  wire logic [WORD_W-1:0] data_i,
    output logic                   msb_o
);
    logic [WORD_W-1:0] sr_q;

    // A load on the same edge as a shift wins: that is the zero-bubble word handoff.
    always_ff @(posedge cfg_clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (clear_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[WORD_W-2:0], 1'b0};
        end
    end

    assign msb_o = sr_q[WORD_W-1];
endmodule
`default_nettype wire

// File: rtl/cfg_loader.sv
`default_nettype none
// ============================================================
// cfg_loader : sequences exactly CHAIN_LEN bits, MSB-first, into the scan chain
// Rev 1.0
// ============================================================
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8
) (
    input  wire logic   cfg_clk,
    input  wire logic   rst_n,
    cfg_loader_if.slave bus
);
    localparam int NWORDS    = cfg_nwords(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int BCW       = $clog2(CHAIN_LEN + 1);
    localparam int WBW       = $clog2(WORD_W + 1);
    localparam int WCW       = $clog2(NWORDS + 1);

    cfg_state_e     state_q, state_d;
    logic [BCW-1:0] bits_left_q, bits_left_d;
    logic [WBW-1:0] word_bits_q, word_bits_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic           cfg_valid_q, cfg_valid_d;

    logic           sr_load, sr_clear, sr_shift, sr_msb;
    logic           last_word_bit, last_chain_bit, accept;
    logic [WBW-1:0] next_word_bits;

    assign last_word_bit  = (word_bits_q == WBW'(1));
    assign last_chain_bit = (bits_left_q == BCW'(1));
    assign accept         = bus.word_valid && bus.word_ready;
    // Only the final word can be short; its low bits are never shifted.
    assign next_word_bits = (word_cnt_q == WCW'(NWORDS - 1)) ? WBW'(LAST_BITS) : WBW'(WORD_W);
    assign sr_shift       = (state_q == SHIFT);

    assign bus.word_ready = (state_q == LOAD) ||
                            ((state_q == SHIFT) && last_word_bit && !last_chain_bit);
    assign bus.cfg_en     = (state_q == SHIFT);
    assign bus.cfg_head   = (state_q == SHIFT) && sr_msb;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.cfg_valid  = cfg_valid_q;

    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        word_bits_d = word_bits_q;
        word_cnt_d  = word_cnt_q;
        cfg_valid_d = cfg_valid_q;
        sr_load     = 1'b0;
        sr_clear    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cfg_valid_d = 1'b0;
                    bits_left_d = BCW'(CHAIN_LEN);
                    word_cnt_d  = '0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    sr_load     = 1'b1;
                    word_bits_d = next_word_bits;
                    word_cnt_d  = word_cnt_q + WCW'(1);
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                bits_left_d = bits_left_q - BCW'(1);
                word_bits_d = word_bits_q - WBW'(1);
                if (last_chain_bit) begin
                    state_d = DONE;
                end else if (last_word_bit) begin
                    if (accept) begin
                        sr_load     = 1'b1;
                        word_bits_d = next_word_bits;
                        word_cnt_d  = word_cnt_q + WCW'(1);
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                cfg_valid_d = 1'b1;
                word_cnt_d  = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything; a start seen alongside it still invalidates.
        if (bus.abort) begin
            state_d     = IDLE;
            bits_left_d = '0;
            word_bits_d = '0;
            word_cnt_d  = '0;
            sr_load     = 1'b0;
            sr_clear    = (state_q != IDLE);
            if ((state_q != IDLE) || bus.start) begin
                cfg_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge cfg_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bits_left_q <= '0;
            word_bits_q <= '0;
            word_cnt_q  <= '0;
            cfg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            word_bits_q <= word_bits_d;
            word_cnt_q  <= word_cnt_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

    cfg_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .cfg_clk (cfg_clk),
        .rst_n   (rst_n),
        .clear_i (sr_clear),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (bus.word_data),
        .msb_o   (sr_msb)
    );
endmodule
`default_nettype wire

// File: tb/tb_cfg_loader.sv
`default_nettype none
// ============================================================
// tb_cfg_loader : directed self-checking bench, 16-bit and 20-bit chains
// Rev 1.0
// ============================================================
module tb_cfg_loader;
    logic cfg_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 cfg_clk = ~cfg_clk;

    int vectors    = 0;
    int miscompares = 0;

    logic       sel     = 1'b0;
    logic       t_start = 1'b0;
    logic       t_abort = 1'b0;
    logic       t_valid = 1'b0;
    logic [7:0] t_data  = 8'h00;

    cfg_loader_if #(.WORD_W(8)) bus16 ();
    cfg_loader_if #(.WORD_W(8)) bus20 ();

    assign bus16.start      = t_start & ~sel;
    assign bus16.abort      = t_abort & ~sel;
    assign bus16.word_valid = t_valid & ~sel;
    assign bus16.word_data  = t_data;
    assign bus20.start      = t_start & sel;
    assign bus20.abort      = t_abort & sel;
    assign bus20.word_valid = t_valid & sel;
    assign bus20.word_data  = t_data;

    cfg_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (.cfg_clk(cfg_clk), .rst_n(rst_n), .bus(bus16));
    cfg_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (.cfg_clk(cfg_clk), .rst_n(rst_n), .bus(bus20));

    logic o_ready, o_en, o_head, o_busy, o_done, o_valid;
    assign o_ready = sel ? bus20.word_ready : bus16.word_ready;
    assign o_en    = sel ? bus20.cfg_en     : bus16.cfg_en;
    assign o_head  = sel ? bus20.cfg_head   : bus16.cfg_head;
    assign o_busy  = sel ? bus20.busy       : bus16.busy;
    assign o_done  = sel ? bus20.done       : bus16.done;
    assign o_valid = sel ? bus20.cfg_valid  : bus16.cfg_valid;

    // Behavioural ConfigChain: first bit shifted ends at the top position.
    logic [15:0] chain16;
    logic [19:0] chain20;
    always @(posedge cfg_clk) begin
        if (bus16.cfg_en) chain16 <= {chain16[14:0], bus16.cfg_head};
        if (bus20.cfg_en) chain20 <= {chain20[18:0], bus20.cfg_head};
    end

    logic [7:0] words [0:3];
    int res_en, res_first, res_last, res_done_cnt, res_done_cyc, res_valid_cyc, res_idle_cyc;
    logic res_valid1, res_busy_end;

    // Cycle n is the period following edge n-1; start is sampled at edge 0.
    task automatic run_load(input int nw, input int stall, input int abort_at,
                            input int start_at, input int ncyc);
        int idx = 0;
        int withheld = 0;
        bit hs = 1'b0;
        res_en = 0; res_first = -1; res_last = -1; res_done_cnt = 0;
        res_done_cyc = -1; res_valid_cyc = -1; res_idle_cyc = -1; res_valid1 = 1'bx;
        @(negedge cfg_clk);
        t_start = 1'b1; t_abort = 1'b0; t_valid = 1'b1; t_data = words[0];
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge cfg_clk);
            if (o_en) begin
                res_en++;
                if (res_first < 0) res_first = cyc;
                res_last = cyc;
            end
            if (o_done) begin res_done_cnt++; res_done_cyc = cyc; end
            if (o_valid && res_valid_cyc < 0) res_valid_cyc = cyc;
            if (!o_busy && cyc >= 2 && res_idle_cyc < 0) res_idle_cyc = cyc;
            if (cyc == 1) res_valid1 = o_valid;
            t_start = (cyc == start_at);
            t_abort = (abort_at > 0) && o_en && (res_en == abort_at);
            if (hs) idx++;
            t_data  = (idx < nw) ? words[idx] : 8'h00;
            t_valid = (idx < nw);
            if (idx == 1 && withheld < stall) begin
                t_valid = 1'b0;
                if (o_ready) withheld++;
            end
            hs = o_ready && t_valid;
        end
        t_start = 1'b0; t_abort = 1'b0; t_valid = 1'b0;
        res_busy_end = o_busy;
    endtask

    task automatic test_reset();
        sel = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge cfg_clk);
        vectors++; if (bus16.cfg_en !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_en: got %b expected 0", bus16.cfg_en); end
        vectors++; if (bus16.cfg_head !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_head: got %b expected 0", bus16.cfg_head); end
        vectors++; if (bus16.word_ready !== 1'b0) begin miscompares++; $display("FAIL reset_word_ready: got %b expected 0", bus16.word_ready); end
        vectors++; if (bus16.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus16.busy); end
        vectors++; if (bus16.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus16.done); end
        vectors++; if (bus16.cfg_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_valid: got %b expected 0", bus16.cfg_valid); end
        vectors++; if ({bus20.busy, bus20.cfg_valid, bus20.cfg_en} !== 3'b000) begin miscompares++; $display("FAIL reset_dut20: got %b expected 000", {bus20.busy, bus20.cfg_valid, bus20.cfg_en}); end
        rst_n = 1'b1;
        @(negedge cfg_clk);
    endtask

    task automatic test_basic16();
        sel = 1'b0; words[0] = 8'hA5; words[1] = 8'h3C;
        run_load(2, 0, 0, 0, 28);
        vectors++; if (res_en !== 16) begin miscompares++; $display("FAIL basic_shift_count: got %0d expected 16", res_en); end
        vectors++; if (res_first !== 2 || res_last !== 17) begin miscompares++; $display("FAIL basic_en_window: got %0d..%0d expected 2..17", res_first, res_last); end
        vectors++; if (chain16 !== 16'hA53C) begin miscompares++; $display("FAIL basic_chain: got %h expected a53c", chain16); end
        vectors++; if (res_done_cyc !== 18 || res_done_cnt !== 1) begin miscompares++; $display("FAIL basic_done: got cycle %0d count %0d expected cycle 18 count 1", res_done_cyc, res_done_cnt); end
        vectors++; if (res_valid_cyc !== 19) begin miscompares++; $display("FAIL basic_cfg_valid_cycle: got %0d expected 19", res_valid_cyc); end
        vectors++; if (res_idle_cyc !== 19 || res_busy_end !== 1'b0) begin miscompares++; $display("FAIL basic_idle: got cycle %0d busy_end %b expected 19 0", res_idle_cyc, res_busy_end); end
    endtask

    task automatic test_stall();
        sel = 1'b0; words[0] = 8'hA5; words[1] = 8'h3C;
        run_load(2, 3, 0, 0, 28);
        vectors++; if (res_valid1 !== 1'b0) begin miscompares++; $display("FAIL stall_valid_cleared: got %b expected 0", res_valid1); end
        vectors++; if (res_en !== 16) begin miscompares++; $display("FAIL stall_shift_count: got %0d expected 16", res_en); end
        vectors++; if (res_first !== 2 || res_last !== 20) begin miscompares++; $display("FAIL stall_en_window: got %0d..%0d expected 2..20", res_first, res_last); end
        vectors++; if (chain16 !== 16'hA53C) begin miscompares++; $display("FAIL stall_chain: got %h expected a53c", chain16); end
        vectors++; if (res_done_cyc !== 21 || res_valid_cyc !== 22) begin miscompares++; $display("FAIL stall_done: got done %0d valid %0d expected 21 22", res_done_cyc, res_valid_cyc); end
    endtask

    task automatic test_partial20();
        sel = 1'b1; words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'h9F;
        run_load(3, 0, 0, 0, 28);
        vectors++; if (res_en !== 20) begin miscompares++; $display("FAIL partial_shift_count: got %0d expected 20", res_en); end
        vectors++; if (chain20 !== 20'hFF009) begin miscompares++; $display("FAIL partial_chain: got %h expected ff009", chain20); end
        vectors++; if (res_done_cyc !== 22 || res_valid_cyc !== 23) begin miscompares++; $display("FAIL partial_done: got done %0d valid %0d expected 22 23", res_done_cyc, res_valid_cyc); end
        sel = 1'b0;
    endtask

    task automatic test_abort();
        sel = 1'b0; words[0] = 8'hA5; words[1] = 8'h3C;
        run_load(2, 0, 5, 0, 28);
        vectors++; if (res_en !== 5) begin miscompares++; $display("FAIL abort_shift_count: got %0d expected 5", res_en); end
        vectors++; if (res_idle_cyc !== 7) begin miscompares++; $display("FAIL abort_idle_cycle: got %0d expected 7", res_idle_cyc); end
        vectors++; if (res_done_cnt !== 0 || res_valid_cyc !== -1) begin miscompares++; $display("FAIL abort_no_done: got done %0d valid_cycle %0d expected 0 -1", res_done_cnt, res_valid_cyc); end
        run_load(2, 0, 0, 0, 28);
        vectors++; if (chain16 !== 16'hA53C || res_en !== 16) begin miscompares++; $display("FAIL abort_reload: got chain %h shifts %0d expected a53c 16", chain16, res_en); end
        vectors++; if (res_done_cyc !== 18 || o_valid !== 1'b1) begin miscompares++; $display("FAIL abort_reload_done: got done %0d valid %b expected 18 1", res_done_cyc, o_valid); end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; words[0] = 8'hA5; words[1] = 8'h3C;
        run_load(2, 0, 0, 6, 28);
        vectors++; if (res_en !== 16 || res_done_cnt !== 1) begin miscompares++; $display("FAIL busy_start_ignored: got shifts %0d done %0d expected 16 1", res_en, res_done_cnt); end
        vectors++; if (chain16 !== 16'hA53C || res_idle_cyc !== 19) begin miscompares++; $display("FAIL busy_start_chain: got %h idle %0d expected a53c 19", chain16, res_idle_cyc); end
        t_start = 1'b1; t_abort = 1'b1;
        @(negedge cfg_clk);
        t_start = 1'b0; t_abort = 1'b0;
        vectors++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin miscompares++; $display("FAIL start_abort_idle: got busy %b valid %b expected 0 0", o_busy, o_valid); end
        @(negedge cfg_clk);
        vectors++; if (o_busy !== 1'b0 || o_en !== 1'b0) begin miscompares++; $display("FAIL start_abort_stays: got busy %b en %b expected 0 0", o_busy, o_en); end
    endtask

    task automatic test_async_reset();
        sel = 1'b0; words[0] = 8'hA5; words[1] = 8'h3C;
        @(negedge cfg_clk);
        t_start = 1'b1; t_valid = 1'b1; t_data = 8'hA5;
        @(negedge cfg_clk);
        t_start = 1'b0;
        repeat (4) @(negedge cfg_clk);
        vectors++; if (o_en !== 1'b1) begin miscompares++; $display("FAIL midshift_en: got %b expected 1", o_en); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({o_en, o_head, o_ready, o_busy, o_done, o_valid} !== 6'b0) begin miscompares++; $display("FAIL async_reset_outputs: got %b expected 000000", {o_en, o_head, o_ready, o_busy, o_done, o_valid}); end
        t_valid = 1'b0;
        @(negedge cfg_clk);
        rst_n = 1'b1;
        run_load(2, 0, 0, 0, 28);
        vectors++; if (chain16 !== 16'hA53C || res_done_cyc !== 18) begin miscompares++; $display("FAIL reset_reload: got chain %h done %0d expected a53c 18", chain16, res_done_cyc); end
    endtask

    initial begin
        test_reset();
        test_basic16();
        test_stall();
        test_partial20();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
